// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - EX-stage multiply/divide sequencer owning HI/LO.
// Holds the front end via md_stall while a mult/div is in flight.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        wr_en,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        md_useD,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0]        a_ext, b_ext, prod;
  logic [31:0]        quo, rem;

  // Arithmetic works only on the operands latched at start.
  always_comb begin
    a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod  = a_ext * b_ext;
    quo   = '0;
    rem   = '0;
    if (b_q != '0) begin
      if (sgn_q) begin
        // The one signed quotient that does not fit in 32 bits wraps to itself.
        if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          quo = 32'h8000_0000;
          rem = '0;
        end else begin
          quo = 32'($signed(a_q) / $signed(b_q));
          rem = 32'($signed(a_q) % $signed(b_q));
        end
      end else begin
        quo = a_q / b_q;
        rem = a_q % b_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush && !op[2]) begin
          state_d = op[1] ? S_DIV : S_MUL;
          count_d = op[1] ? DIV_LOAD : MUL_LOAD;
          a_d     = src_a;
          b_d     = src_b;
          sgn_d   = !op[0];
        end else if (wr_en && op == 3'd4) begin
          hi_d = src_a;
        end else if (wr_en && op == 3'd5) begin
          lo_d = src_a;
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = S_IDLE;
          if (state_q == S_MUL) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign md_stall = md_useD & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
